// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests one word at the current PC, holds it for execute,
// then computes the next PC (sequential, taken branch or jump). A fetched OP of 6'b111111 halts.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic        execDone,
    output logic        instValid,
    output logic [31:0] inst,
    output logic [5:0]  OP,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4
);

    // state   | meaning
    // IDLE    | quiescent for one cycle after reset release
    // FETCH   | request outstanding at pc_q, waiting for imemAck
    // HOLD    | instruction valid, waiting for execDone
    // HALT    | halt opcode fetched; frozen until reset
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [5:0] OP_HALT = 6'b111111;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jmp_target;

    assign pc_plus4   = pc_out_q + 32'd4;
    assign br_target  = pc_plus4 + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    assign jmp_target = {pc_plus4[31:28], inst_q[25:0], 2'b00};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imemAck) begin
                    inst_d   = imemData;
                    pc_out_d = pc_q;
                    state_d  = (imemData[31:26] == OP_HALT) ? S_HALT : S_HOLD;
                end
            end
            S_HOLD: begin
                if (execDone) begin
                    // jump wins over a simultaneous branch
                    if (jump)
                        pc_d = jmp_target;
                    else if (branch && zero)
                        pc_d = br_target;
                    else
                        pc_d = pc_plus4;
                    state_d = S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= 32'd0;
            pc_out_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign imemReq   = (state_q == S_FETCH);
    assign imemAddr  = pc_q;
    assign instValid = (state_q == S_HOLD);
    assign inst      = inst_q;
    assign OP        = inst_q[31:26];
    assign rs        = inst_q[25:21];
    assign rt        = inst_q[20:16];
    assign rd        = inst_q[15:11];
    assign funct     = inst_q[5:0];
    assign imm16     = inst_q[15:0];
    assign pcOut     = pc_out_q;
    assign pcPlus4   = pc_plus4;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed PC scenarios followed by random fetch/execute
// traffic compared against a PC/instruction model built from the fetch rules.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemData = 32'd0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        zero = 1'b0;
    logic        execDone = 1'b0;
    logic        instValid;
    logic [31:0] inst;
    logic [5:0]  OP;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_pcout;
    logic [31:0] halt_pc;
    logic [31:0] rword;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
        .branch(branch), .jump(jump), .zero(zero), .execDone(execDone),
        .instValid(instValid), .inst(inst), .OP(OP), .rs(rs), .rt(rt), .rd(rd),
        .funct(funct), .imm16(imm16), .pcOut(pcOut), .pcPlus4(pcPlus4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Fetch one word after lat wait cycles; spurious execDone during FETCH must be ignored.
    task automatic do_fetch(input logic [31:0] word, input int lat);
        int n;
        n = 0;
        while (imemReq !== 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", {31'd0, imemReq}, 32'd1);
        for (int i = 0; i < lat; i++) begin
            chk("fetch_addr", imemAddr, exp_pc);
            execDone = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("fetch_wait_invalid", {31'd0, instValid}, 32'd0);
        end
        execDone = 1'b0;
        chk("fetch_addr_ack", imemAddr, exp_pc);
        imemAck  = 1'b1;
        imemData = word;
        @(negedge clk);
        imemAck  = 1'b0;
        imemData = $urandom;
        exp_inst  = word;
        exp_pcout = exp_pc;
        if (word[31:26] == 6'b111111) begin
            chk("halt_valid", {31'd0, instValid}, 32'd0);
            chk("halt_req", {31'd0, imemReq}, 32'd0);
        end else begin
            chk("hold_valid", {31'd0, instValid}, 32'd1);
            chk("hold_req", {31'd0, imemReq}, 32'd0);
            chk("inst", inst, exp_inst);
            chk("op", {26'd0, OP}, {26'd0, exp_inst[31:26]});
            chk("rs", {27'd0, rs}, {27'd0, exp_inst[25:21]});
            chk("rt", {27'd0, rt}, {27'd0, exp_inst[20:16]});
            chk("rd", {27'd0, rd}, {27'd0, exp_inst[15:11]});
            chk("funct", {26'd0, funct}, {26'd0, exp_inst[5:0]});
            chk("imm16", {16'd0, imm16}, {16'd0, exp_inst[15:0]});
            chk("pc_out", pcOut, exp_pcout);
            chk("pc_plus4", pcPlus4, exp_pcout + 32'd4);
        end
    endtask

    // Hold for some cycles (spurious acks ignored), then retire with the given control bits.
    task automatic do_exec(input logic j, input logic b, input logic z, input int hold);
        logic [31:0] p4;
        int off;
        for (int i = 0; i < hold; i++) begin
            imemAck  = 1'($urandom_range(0, 1));
            imemData = $urandom;
            @(negedge clk);
            chk("hold_stable_valid", {31'd0, instValid}, 32'd1);
            chk("hold_stable_inst", inst, exp_inst);
            chk("hold_stable_pc", pcOut, exp_pcout);
        end
        imemAck  = 1'b0;
        jump     = j;
        branch   = b;
        zero     = z;
        execDone = 1'b1;
        @(negedge clk);
        execDone = 1'b0;
        jump     = 1'b0;
        branch   = 1'b0;
        zero     = 1'b0;
        p4 = exp_pcout + 32'd4;
        if (j)
            exp_pc = {p4[31:28], exp_inst[25:0], 2'b00};
        else if (b && z) begin
            off = int'($signed(exp_inst[15:0])) * 4;
            exp_pc = p4 + 32'(off);
        end else
            exp_pc = p4;
        chk("exec_drop_valid", {31'd0, instValid}, 32'd0);
        chk("exec_refetch_req", {31'd0, imemReq}, 32'd1);
        chk("exec_next_addr", imemAddr, exp_pc);
    endtask

    initial begin
        exp_pc = 32'd0; exp_inst = 32'd0; exp_pcout = 32'd0;
        #3;
        chk("rst_req", {31'd0, imemReq}, 32'd0);
        chk("rst_valid", {31'd0, instValid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pcout", pcOut, 32'd0);
        chk("rst_pcplus4", pcPlus4, 32'd4);
        chk("rst_addr", imemAddr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_to_fetch", {31'd0, imemReq}, 32'd1);

        do_fetch(32'h3C01_0012, 3);
        chk("lui_op", {26'd0, OP}, 32'h0000_000F);
        chk("lui_rt", {27'd0, rt}, 32'd1);
        chk("lui_imm", {16'd0, imm16}, 32'h0000_0012);
        do_exec(1'b0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h0000_0000, i);
            do_exec(1'b0, 1'b0, 1'b0, 0);
        end
        chk("at_pc_10", imemAddr, 32'h0000_0010);
        do_fetch(32'h1000_FFFC, 1);
        do_exec(1'b0, 1'b1, 1'b1, 0);
        chk("branch_taken", imemAddr, 32'h0000_0004);
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h0000_0000, 0);
            do_exec(1'b0, 1'b0, 1'b0, 0);
        end
        do_fetch(32'h1000_FFFC, 0);
        do_exec(1'b0, 1'b1, 1'b0, 1);
        chk("branch_not_taken", imemAddr, 32'h0000_0014);

        do_fetch(32'h0BFF_FFFF, 2);
        do_exec(1'b1, 1'b0, 1'b0, 0);
        chk("jump_far", imemAddr, 32'h0FFF_FFFC);
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h0000_0000, 0);
            do_exec(1'b0, 1'b0, 1'b0, 0);
        end
        chk("at_pc_10000008", imemAddr, 32'h1000_0008);
        do_fetch(32'h0800_0040, 1);
        do_exec(1'b1, 1'b1, 1'b1, 1);
        chk("jump_priority", imemAddr, 32'h1000_0100);

        // reset mid-FETCH, then a late ack right after release must be ignored
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_req", {31'd0, imemReq}, 32'd0);
        chk("rst_async_addr", imemAddr, 32'd0);
        chk("rst_async_pcplus4", pcPlus4, 32'd4);
        @(negedge clk);
        rst_n    = 1'b1;
        imemAck  = 1'b1;
        imemData = 32'hDEAD_BEEF;
        @(negedge clk);
        imemAck = 1'b0;
        exp_pc  = 32'd0;
        chk("late_ack_valid", {31'd0, instValid}, 32'd0);
        chk("late_ack_inst", inst, 32'd0);
        chk("refetch_req", {31'd0, imemReq}, 32'd1);
        chk("refetch_addr", imemAddr, 32'd0);

        do_fetch(32'h1000_FFFE, 2);
        do_exec(1'b0, 1'b1, 1'b1, 0);
        chk("branch_neg_wrap", imemAddr, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0000, 1);
        do_exec(1'b0, 1'b0, 1'b0, 0);
        chk("pc_wrap", imemAddr, 32'h0000_0000);

        for (int k = 0; k < 40; k++) begin
            rword = $urandom;
            if (rword[31:26] == 6'b111111) rword[26] = 1'b0;
            do_fetch(rword, int'($urandom_range(0, 3)));
            do_exec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        do_fetch(32'hFC00_0000, 1);
        halt_pc = exp_pc;
        for (int i = 0; i < 20; i++) begin
            execDone = 1'($urandom_range(0, 1));
            imemAck  = 1'($urandom_range(0, 1));
            imemData = $urandom;
            branch   = 1'($urandom_range(0, 1));
            jump     = 1'($urandom_range(0, 1));
            zero     = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_hold_valid", {31'd0, instValid}, 32'd0);
            chk("halt_hold_req", {31'd0, imemReq}, 32'd0);
            chk("halt_hold_addr", imemAddr, halt_pc);
        end
        execDone = 1'b0; imemAck = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("halt_exit_req", {31'd0, imemReq}, 32'd1);
        chk("halt_exit_addr", imemAddr, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imemReq  output  1  instruction-memory read request.
REQ-005 imemAddr  output  32  word-aligned fetch address (= current PC).
REQ-006 imemAck  input  1  memory returns imemData this cycle.
REQ-007 imemData  input  32  fetched instruction word.
REQ-008 branch, jump  input  1 each  control-unit outputs for the instruction held in the instruction register.
REQ-009 zero  input  1  ALU equality flag for the held instruction.
REQ-010 execDone  input  1  downstream has consumed the held instruction.
REQ-011 instValid  output  1  the inst and field outputs are valid.
REQ-012 inst  output  32  held instruction register.
REQ-013 OP [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm16 [15:0]  outputs  slices of inst.
REQ-014 pcOut  output  32  address of the held instruction; pcPlus4  output  32  pcOut+4.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, HOLD, HALT.
REQ-016 IDLE: outputs quiescent; SHALL move unconditionally to FETCH on the next edge.
REQ-017 FETCH: imemReq=1, imemAddr=PC held stable until imemAck; on imemAck the block SHALL latch imemData into inst, set pcOut=PC, and enter HOLD (fetch latency = memory ack cycle + 1).
REQ-018 imemReq SHALL be 0 in every state except FETCH; imemAck outside FETCH SHALL be ignored.
REQ-019 HOLD: instValid=1, inst/fields/pcOut stable until execDone.
REQ-020 On execDone in HOLD, next PC SHALL be: jump=1 -> {pcPlus4[31:28], inst[25:0], 2'b00}; else branch=1 and zero=1 -> pcPlus4 + (sign-extended imm16 << 2); else pcPlus4; then the FSM enters FETCH.
REQ-021 jump SHALL take priority when jump and branch are both 1.
REQ-022 All PC arithmetic SHALL be modulo 2^32 (PC 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000); imemAddr[1:0] SHALL always be 00.
REQ-023 If the latched OP is 6'b111111, the FSM SHALL enter HALT instead of HOLD; HALT SHALL hold instValid=0, imemReq=0, PC frozen, and is exited only by reset.
REQ-024 execDone outside HOLD SHALL be ignored.
REQ-025 instValid SHALL drop to 0 in the cycle after execDone is accepted and stay 0 until the next imemAck.

Reset
REQ-026 rst_n=0 SHALL immediately (no clock edge required) force state=IDLE, PC=RESET_PC, imemReq=0, instValid=0, inst=0, pcOut=0, pcPlus4=4.
REQ-027 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the transaction; a late imemAck arriving after reset deassertion but before re-entering FETCH SHALL be ignored.
REQ-028 Release of rst_n SHALL take effect at the next rising clk edge, beginning in IDLE.

Verification
REQ-029 Reset release, memory acks after 3 cycles with 32'h3C01_0012 -> imemAddr=0 for 3 cycles, then instValid=1, OP=6'b001111, rt=1, imm16=16'h0012, pcOut=0.
REQ-030 Held at PC 32'h0000_0010, branch=1, zero=1, imm16=16'hFFFC, execDone -> next imemAddr=32'h0000_0004; same with zero=0 -> 32'h0000_0014.
REQ-031 PC 32'h1000_0008, inst 32'h0800_0040, jump=1 and branch=1, execDone -> next imemAddr=32'h1000_0100.
REQ-032 PC 32'hFFFF_FFFC, no branch/jump, execDone -> next imemAddr=32'h0000_0000.
REQ-033 rst_n pulsed low mid-FETCH with imemAck arriving 1 cycle after release -> imemReq drops asynchronously, ack ignored, refetch from RESET_PC.
REQ-034 Fetch 32'hFC00_0000 -> HALT, instValid=0, imemReq=0 for 20 cycles regardless of execDone/imemAck.
